slink_tx_pkt_arbiter: RTL and testbench

- Shares one S-Link application TX packet interface (tx_sop/tx_data_id/tx_word_count/tx_app_data/tx_advance) between NUM_REQ packet sources, e.g. the APB bridge plus GPIO/other app agents.
- Round-robin arbitration, packet-granular: a grant is held until the granted packet's last beat is accepted by the link.
- Sits in the link_clk domain between the requesters and the S-Link controller application port.

---
 rtl/slink_tx_pkt_arbiter_if.sv | 27 ++
 rtl/slink_tx_pkt_arbiter.sv | 135 +++++++++++++
 tb/tb_slink_tx_pkt_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slink_tx_pkt_arbiter_if.sv
// Shared TX packet bundle between the requesters, the packet arbiter and the S-Link app port.
// slave is the arbiter's view; master is the view of the requesters plus the link.
interface slink_tx_pkt_arbiter_if #(
  parameter int unsigned NUM_REQ           = 2,
  parameter int unsigned TX_APP_DATA_WIDTH = 128
);
  logic [NUM_REQ-1:0]                   req_sop;
  logic [NUM_REQ*8-1:0]                 req_data_id;
  logic [NUM_REQ*16-1:0]                req_word_count;
  logic [NUM_REQ*TX_APP_DATA_WIDTH-1:0] req_app_data;
  logic [NUM_REQ-1:0]                   req_advance;
  logic                                 tx_sop;
  logic [7:0]                           tx_data_id;
  logic [15:0]                          tx_word_count;
  logic [TX_APP_DATA_WIDTH-1:0]         tx_app_data;
  logic                                 tx_advance;

  modport slave (
    input  req_sop, req_data_id, req_word_count, req_app_data, tx_advance,
    output req_advance, tx_sop, tx_data_id, tx_word_count, tx_app_data
  );

  modport master (
    output req_sop, req_data_id, req_word_count, req_app_data, tx_advance,
    input  req_advance, tx_sop, tx_data_id, tx_word_count, tx_app_data
  );
endinterface

// File: rtl/slink_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one S-Link application TX port
// among NUM_REQ packet sources; a grant is held until the packet's last beat is accepted.
module slink_tx_pkt_arbiter #(
  parameter int unsigned NUM_REQ           = 2,
  parameter int unsigned TX_APP_DATA_WIDTH = 128,
  parameter logic [7:0]  SHORT_PKT_MAX_DT  = 8'h2F
) (
  input  logic                           link_clk,
  input  logic                           link_reset_n,
  input  logic                           enable,
  slink_tx_pkt_arbiter_if.slave          bus,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy
);

  localparam int unsigned BYTES = TX_APP_DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [16:0]         beats_q, beats_d;

  logic [7:0]                   dt_a   [NUM_REQ];
  logic [15:0]                  wc_a   [NUM_REQ];
  logic [TX_APP_DATA_WIDTH-1:0] data_a [NUM_REQ];

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      dt_a[i]   = bus.req_data_id[8*i +: 8];
      wc_a[i]   = bus.req_word_count[16*i +: 16];
      data_a[i] = bus.req_app_data[TX_APP_DATA_WIDTH*i +: TX_APP_DATA_WIDTH];
    end
  end

  // Round-robin search starting just after the previous owner.
  logic            sel_vld;
  logic [IdxW-1:0] sel_idx;
  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(last_q) + k) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!sel_vld && bus.req_sop[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  logic [16:0] sel_beats;
  always_comb begin
    if (dt_a[sel_idx] <= SHORT_PKT_MAX_DT || wc_a[sel_idx] == 16'd0) begin
      sel_beats = 17'd1;
    end else begin
      sel_beats = ({1'b0, wc_a[sel_idx]} + 17'(BYTES - 1)) / 17'(BYTES);
    end
  end

  assign busy  = (state_q == StPkt);
  assign grant = grant_q;

  // While busy the owner is always last_q, so it doubles as the mux select.
  always_comb begin
    bus.tx_sop        = 1'b0;
    bus.tx_data_id    = '0;
    bus.tx_word_count = '0;
    bus.tx_app_data   = '0;
    if (busy) begin
      bus.tx_sop        = bus.req_sop[last_q];
      bus.tx_data_id    = dt_a[last_q];
      bus.tx_word_count = wc_a[last_q];
      bus.tx_app_data   = data_a[last_q];
    end
    bus.req_advance = (busy && bus.tx_advance) ? grant_q : '0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beats_d = beats_q;
    unique case (state_q)
      StIdle: begin
        if (enable && sel_vld) begin
          state_d          = StPkt;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          last_d           = sel_idx;
          beats_d          = sel_beats;
        end
      end
      StPkt: begin
        if (!bus.req_sop[last_q]) begin
          // Owner abandoned its packet: drop the remaining beats.
          state_d = StIdle;
          grant_d = '0;
          beats_d = '0;
        end else if (bus.tx_advance) begin
          beats_d = beats_q - 17'd1;
          if (beats_q == 17'd1) begin
            state_d = StIdle;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge link_clk or negedge link_reset_n) begin
    if (!link_reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: tb/tb_slink_tx_pkt_arbiter.sv
// Bench for slink_tx_pkt_arbiter: directed scenarios followed by randomized packets,
// checked against a transaction-level round-robin and beat-count model.
module tb_slink_tx_pkt_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 128;

  logic            link_clk = 1'b0;
  logic            link_reset_n;
  logic            enable;
  logic [NREQ-1:0] grant;
  logic            busy;

  slink_tx_pkt_arbiter_if #(.NUM_REQ(NREQ), .TX_APP_DATA_WIDTH(W)) bus ();

  slink_tx_pkt_arbiter #(
    .NUM_REQ          (NREQ),
    .TX_APP_DATA_WIDTH(W),
    .SHORT_PKT_MAX_DT (8'h2F)
  ) dut (
    .link_clk    (link_clk),
    .link_reset_n(link_reset_n),
    .enable      (enable),
    .bus         (bus.slave),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 link_clk = ~link_clk;

  int n_pass  = 0;
  int n_total = 0;
  int last_rr;

  logic [7:0]   m_dt   [NREQ];
  logic [15:0]  m_wc   [NREQ];
  logic [W-1:0] m_data [NREQ];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge link_clk);
    #1;
  endtask

  // Round-robin reference: next requester after the last winner, wrapping.
  function automatic int arb(input logic [NREQ-1:0] m);
    for (int k = 1; k <= int'(NREQ); k++) begin
      int c;
      c = (last_rr + k) % int'(NREQ);
      if (m[c]) begin
        last_rr = c;
        return c;
      end
    end
    return -1;
  endfunction

  function automatic int beats_of(input logic [7:0] dt, input logic [15:0] wc);
    if (dt <= 8'h2F) return 1;
    if (wc == 16'd0) return 1;
    return (int'(wc) + int'(W / 8) - 1) / int'(W / 8);
  endfunction

  task automatic set_req(input int i, input logic sop, input logic [7:0] dt,
                         input logic [15:0] wc, input logic [W-1:0] d);
    bus.req_sop[i]               = sop;
    bus.req_data_id[8*i +: 8]    = dt;
    bus.req_word_count[16*i +: 16] = wc;
    bus.req_app_data[W*i +: W]   = d;
    m_dt[i]   = dt;
    m_wc[i]   = wc;
    m_data[i] = d;
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Grant appears after the next edge; then beats are consumed until release.
  task automatic drain(input int who, input int beats, input bit rnd, input bit drop_en);
    logic [NREQ-1:0] oh;
    int   got, cyc;
    bit   stray, lost;
    logic adv;
    oh = '0;
    if (who >= 0) oh[who] = 1'b1;
    step();
    chk("grant", grant, oh);
    chk("busy", busy, 1);
    chk("tx_sop", bus.tx_sop, 1);
    chk("tx_data_id", bus.tx_data_id, m_dt[who]);
    chk("tx_word_count", bus.tx_word_count, m_wc[who]);
    chk("tx_app_data", bus.tx_app_data, m_data[who]);
    if (drop_en) enable = 1'b0;
    got = 0; cyc = 0; stray = 0; lost = 0;
    while (got < beats && cyc < 4 * beats + 20) begin
      adv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.tx_advance = adv;
      #1;
      if (grant !== oh || busy !== 1'b1) lost = 1;
      if (bus.req_advance !== (adv ? oh : '0)) stray = 1;
      if (bus.req_advance[who] === 1'b1) got++;
      step();
      cyc++;
    end
    bus.tx_advance = 1'b0;
    chk("beat_count", got, beats);
    chk("adv_routing", stray, 0);
    chk("grant_held", lost, 0);
    chk("release_grant", grant, 0);
    chk("release_busy", busy, 0);
    chk("release_tx_sop", bus.tx_sop, 0);
  endtask

  initial begin
    int w;
    bit bad;
    link_reset_n       = 1'b0;
    enable             = 1'b1;
    bus.req_sop        = '0;
    bus.req_data_id    = '0;
    bus.req_word_count = '0;
    bus.req_app_data   = '0;
    bus.tx_advance     = 1'b1;
    last_rr            = NREQ - 1;
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, 8'h0, 16'h0, '0);
    set_req(0, 1'b1, 8'h55, 16'h77, rnd_data());
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_sop", bus.tx_sop, 0);
    chk("rst_tx_data_id", bus.tx_data_id, 0);
    chk("rst_tx_word_count", bus.tx_word_count, 0);
    chk("rst_tx_app_data", bus.tx_app_data, 0);
    chk("rst_req_advance", bus.req_advance, 0);
    set_req(0, 1'b0, 8'h0, 16'h0, '0);
    step();
    step();
    link_reset_n = 1'b1;

    // tx_advance while idle must be ignored
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.req_advance !== '0 || grant !== '0 || busy !== 1'b0) bad = 1;
    end
    bus.tx_advance = 1'b0;
    chk("idle_advance_ignored", bad, 0);

    // Single long packet: 40 bytes over 16-byte beats
    set_req(0, 1'b1, 8'h32, 16'd40, rnd_data());
    #1;
    chk("pre_grant_tx_sop", bus.tx_sop, 0);
    w = arb(2'b01);
    drain(w, beats_of(8'h32, 16'd40), 0, 0);
    set_req(0, 1'b0, 8'h0, 16'h0, '0);

    // Short packet carries word count as payload
    set_req(1, 1'b1, 8'h10, 16'h1234, rnd_data());
    w = arb(2'b10);
    drain(w, 1, 0, 0);
    set_req(1, 1'b0, 8'h0, 16'h0, '0);

    // Contention with both requesters held: grants alternate
    set_req(0, 1'b1, 8'h32, 16'd32, rnd_data());
    set_req(1, 1'b1, 8'h33, 16'd17, rnd_data());
    for (int p = 0; p < 4; p++) begin
      w = arb(2'b11);
      drain(w, 2, 1, 0);
    end
    set_req(0, 1'b0, 8'h0, 16'h0, '0);
    set_req(1, 1'b0, 8'h0, 16'h0, '0);

    // Long packet with zero word count, then the largest word count
    set_req(0, 1'b1, 8'h40, 16'h0000, rnd_data());
    w = arb(2'b01);
    drain(w, 1, 0, 0);
    set_req(0, 1'b0, 8'h0, 16'h0, '0);
    set_req(1, 1'b1, 8'h32, 16'hFFFF, rnd_data());
    w = arb(2'b10);
    drain(w, 4096, 0, 0);
    set_req(1, 1'b0, 8'h0, 16'h0, '0);

    // enable dropped mid-packet: packet completes, pending requester waits
    set_req(0, 1'b1, 8'h32, 16'd64, rnd_data());
    set_req(1, 1'b1, 8'h32, 16'd20, rnd_data());
    w = arb(2'b11);
    drain(w, 4, 1, 1);
    set_req(w, 1'b0, 8'h0, 16'h0, '0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (grant !== '0 || busy !== 1'b0) bad = 1;
    end
    chk("no_grant_when_disabled", bad, 0);
    enable = 1'b1;
    w = arb(NREQ'(1) << (1 - w));
    drain(w, 2, 0, 0);
    set_req(w, 1'b0, 8'h0, 16'h0, '0);

    // Async reset mid-packet, after two of four beats
    set_req(1, 1'b1, 8'h32, 16'd64, rnd_data());
    step();
    chk("pre_rst_grant", grant, 2'b10);
    bus.tx_advance = 1'b1;
    step();
    step();
    #2;
    link_reset_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_tx_sop", bus.tx_sop, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_advance", bus.req_advance, 0);
    step();
    chk("midrst_req_advance_held", bus.req_advance, 0);
    bus.tx_advance = 1'b0;
    link_reset_n = 1'b1;
    last_rr = NREQ - 1;
    set_req(0, 1'b1, 8'h32, 16'd64, rnd_data());
    w = arb(2'b11);
    chk("post_rst_first_owner", w, 0);
    drain(w, 4, 1, 0);
    set_req(0, 1'b0, 8'h0, 16'h0, '0);
    w = arb(2'b10);
    drain(w, 4, 1, 0);
    set_req(1, 1'b0, 8'h0, 16'h0, '0);

    // Owner drops req_sop early: grant released next cycle, owner stays recorded
    set_req(0, 1'b1, 8'h32, 16'd64, rnd_data());
    w = arb(2'b01);
    step();
    chk("early_drop_grant", grant, 2'b01);
    bus.tx_advance = 1'b1;
    step();
    bus.tx_advance = 1'b0;
    bus.req_sop[0] = 1'b0;
    step();
    chk("early_drop_release", grant, 0);
    chk("early_drop_busy", busy, 0);
    set_req(0, 1'b1, 8'h32, 16'd16, rnd_data());
    set_req(1, 1'b1, 8'h11, 16'h00AB, rnd_data());
    w = arb(2'b11);
    drain(w, beats_of(m_dt[w], m_wc[w]), 0, 0);

    // Randomized packets and request masks
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < int'(NREQ); i++) begin
        set_req(i, m[i], 8'($urandom_range(0, 255)), 16'($urandom_range(0, 100)), rnd_data());
      end
      w = arb(m);
      drain(w, beats_of(m_dt[w], m_wc[w]), 1, 0);
    end
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, 8'h0, 16'h0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
